rx_frontend: RTL

UART receive front end: oversamples the asynchronous `uart_rx_i` line with the same `cr_clk_div_i`/`cr_ds_i`/`cr_p_i`/`cr_s_i` configuration the transmit front end uses. It decodes one character per frame: start bit, 7 or 8 data bits LSB first, optional parity, 1 or 2 stop bits. Each decoded character is presented to the register bank with a one-cycle `done_o` pulse plus parity and frame error flags. It sits between the UART pad and the receive data register of the Wishbone UART.

---
 rtl/rx_frontend.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_frontend.sv
// UART receive front end: synchronizes the serial line, decodes start/data/parity/stop
// fields and hands each character to the register bank with a one-cycle done pulse.
module rx_frontend (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] cr_clk_div_i,
    input  logic        cr_ds_i,
    input  logic [1:0]  cr_p_i,
    input  logic        cr_s_i,
    input  logic        uart_rx_i,
    output logic [7:0]  dr_o,
    output logic        done_o,
    output logic        parity_error_o,
    output logic        frame_error_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_e;

    // Odd parity expects the inverted data XOR, so the mode bit folds straight in.
    function automatic logic parity_mismatch(input logic rx_bit, input logic data_xor,
                                             input logic odd);
        return rx_bit ^ data_xor ^ odd;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  sync_q;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        par_err_q, par_err_d;
    logic        frm_err_q, frm_err_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic [7:0]  dr_q, dr_d;
    logic        done_q, done_d;
    logic        parity_error_q, parity_error_d;
    logic        frame_error_q, frame_error_d;
    logic        rx_s;
    logic        baud_tick_s;

    assign rx_s        = sync_q[1];
    assign baud_tick_s = (baud_cnt_q == 16'd0);

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rx_i};
        end
    end

    // Frame decoder state and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            baud_cnt_q     <= 16'd0;
            bit_cnt_q      <= 4'd0;
            shift_q        <= 8'd0;
            par_q          <= 1'b0;
            par_err_q      <= 1'b0;
            frm_err_q      <= 1'b0;
            stop_cnt_q     <= 1'b0;
            dr_q           <= 8'd0;
            done_q         <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            baud_cnt_q     <= baud_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            par_q          <= par_d;
            par_err_q      <= par_err_d;
            frm_err_q      <= frm_err_d;
            stop_cnt_q     <= stop_cnt_d;
            dr_q           <= dr_d;
            done_q         <= done_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
        end
    end

    // Next-state, baud timing and field capture.
    always_comb begin
        state_d        = state_q;
        baud_cnt_d     = baud_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        par_d          = par_q;
        par_err_d      = par_err_q;
        frm_err_d      = frm_err_q;
        stop_cnt_d     = stop_cnt_q;
        dr_d           = dr_q;
        done_d         = 1'b0;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;

        if (state_q != ST_IDLE && state_q != ST_WAIT_HIGH) begin
            if (baud_tick_s) begin
                baud_cnt_d = cr_clk_div_i - 16'd1;
            end else begin
                baud_cnt_d = baud_cnt_q - 16'd1;
            end
        end else begin
            baud_cnt_d = baud_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d    = ST_START;
                    baud_cnt_d = {1'b0, cr_clk_div_i[15:1]};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_tick_s) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = cr_ds_i ? 4'd8 : 4'd7;
                        shift_d   = 8'd0;
                        par_d     = 1'b0;
                        par_err_d = 1'b0;
                        frm_err_d = 1'b0;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_tick_s) begin
                    // LSB arrives first, so bits enter at the top of the active width.
                    if (cr_ds_i) begin
                        shift_d = {rx_s, shift_q[7:1]};
                    end else begin
                        shift_d = {1'b0, rx_s, shift_q[6:1]};
                    end
                    par_d     = par_q ^ rx_s;
                    bit_cnt_d = bit_cnt_q - 4'd1;
                    if (bit_cnt_q == 4'd1) begin
                        stop_cnt_d = cr_s_i;
                        if (cr_p_i != 2'b00) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (baud_tick_s) begin
                    par_err_d = parity_mismatch(rx_s, par_q, cr_p_i[0]);
                    state_d   = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (baud_tick_s) begin
                    frm_err_d = frm_err_q | ~rx_s;
                    if (stop_cnt_q) begin
                        stop_cnt_d = 1'b0;
                        state_d    = ST_STOP;
                    end else begin
                        dr_d           = shift_q;
                        done_d         = 1'b1;
                        parity_error_d = (cr_p_i != 2'b00) & par_err_q;
                        frame_error_d  = frm_err_q | ~rx_s;
                        state_d        = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dr_o           = dr_q;
    assign done_o         = done_q;
    assign parity_error_o = parity_error_q;
    assign frame_error_o  = frame_error_q;

endmodule
